// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-split helpers for the set-associative cache
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WBACK,
        ST_REFILL,
        ST_RESP,
        ST_FLUSH
    } cache_state_e;

    localparam int MAX_TAG_W = 32;

    function automatic int byte_bits(int xlen);
        return $clog2(xlen / 8);
    endfunction

    function automatic int offset_bits(int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(int xlen, int sets, int line_words);
        return xlen - index_bits(sets) - offset_bits(line_words) - byte_bits(xlen);
    endfunction

    function automatic int ptr_bits(int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Tag is stored zero-extended so one struct serves every geometry.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [MAX_TAG_W-1:0] tag;
    } cache_meta_t;

endpackage

// File: rtl/assoc_wb_cache_if.sv
// rtl/assoc_wb_cache_if.sv - CPU request/response, memory beat and flush signals of the cache
interface assoc_wb_cache_if #(parameter int XLEN = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN/8-1:0] req_wstrb;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              mem_valid;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;
    logic              flush_req;
    logic              flush_done;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata, flush_req,
        output req_ready, resp_valid, resp_rdata, mem_valid, mem_we, mem_addr, mem_wdata, flush_done
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata, flush_req,
        input  req_ready, resp_valid, resp_rdata, mem_valid, mem_we, mem_addr, mem_wdata, flush_done
    );
endinterface

// File: rtl/cache_way_ram.sv
// rtl/cache_way_ram.sv - one cache way: word data array plus per-set metadata
module cache_way_ram
    import cache_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int SETS       = 256,
    parameter  int LINE_WORDS = 4,
    localparam int IDX_W      = index_bits(SETS),
    localparam int OFF_W      = offset_bits(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [IDX_W-1:0]  rd_index_i,
    input  logic [OFF_W-1:0]  rd_offset_i,
    output logic [XLEN-1:0]   rd_data_o,
    output cache_meta_t       rd_meta_o,
    input  logic              data_we_i,
    input  logic [IDX_W-1:0]  wr_index_i,
    input  logic [OFF_W-1:0]  wr_offset_i,
    input  logic [XLEN-1:0]   wr_data_i,
    input  logic [XLEN/8-1:0] wr_strb_i,
    input  logic              meta_we_i,
    input  cache_meta_t       wr_meta_i
);

    logic [XLEN-1:0] data_q [SETS*LINE_WORDS];
    cache_meta_t     meta_q [SETS];

    assign rd_data_o = data_q[{rd_index_i, rd_offset_i}];
    assign rd_meta_o = meta_q[rd_index_i];

    always_ff @(posedge clk) begin
        if (data_we_i) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (wr_strb_i[b]) data_q[{wr_index_i, wr_offset_i}][b*8 +: 8] <= wr_data_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int s = 0; s < SETS; s++) meta_q[s] <= '0;
        end else if (meta_we_i) begin
            meta_q[wr_index_i] <= wr_meta_i;
        end
    end

endmodule

// File: rtl/assoc_wb_cache.sv
// rtl/assoc_wb_cache.sv - N-way write-back write-allocate cache: miss/flush FSM, beat counter, replacement
module assoc_wb_cache
    import cache_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SETS       = 256,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input logic             clk,
    input logic             rst_b,
    assoc_wb_cache_if.slave bus
);

    localparam int BYTE_W = byte_bits(XLEN);
    localparam int OFF_W  = offset_bits(LINE_WORDS);
    localparam int IDX_W  = index_bits(SETS);
    localparam int TAG_W  = tag_bits(XLEN, SETS, LINE_WORDS);
    localparam int WAY_W  = ptr_bits(WAYS);

    cache_state_e      state_q, state_d;
    logic              req_we_q, req_we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN/8-1:0] wstrb_q, wstrb_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [WAY_W-1:0]  sel_way_q, sel_way_d;
    logic [IDX_W-1:0]  flush_set_q, flush_set_d;
    logic [WAY_W-1:0]  flush_way_q, flush_way_d;
    logic              flush_done_q, flush_done_d;
    logic [WAY_W-1:0]  rr_q [SETS];

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [OFF_W-1:0]     req_off;
    logic [MAX_TAG_W-1:0] req_tag_ext;
    logic                 unused_byte_bits;

    assign req_tag          = addr_q[XLEN-1 -: TAG_W];
    assign req_idx          = addr_q[BYTE_W+OFF_W +: IDX_W];
    assign req_off          = addr_q[BYTE_W +: OFF_W];
    assign req_tag_ext      = MAX_TAG_W'(req_tag);
    assign unused_byte_bits = ^addr_q[BYTE_W-1:0];

    logic [IDX_W-1:0]  rd_index;
    logic [OFF_W-1:0]  rd_offset;
    logic [XLEN-1:0]   rd_data [WAYS];
    cache_meta_t       rd_meta [WAYS];
    logic [WAYS-1:0]   data_we, meta_we;
    logic [OFF_W-1:0]  wr_offset;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN/8-1:0] wr_strb;
    cache_meta_t       wr_meta;

    assign rd_index  = (state_q == ST_FLUSH) ? flush_set_q : req_idx;
    assign rd_offset = (state_q == ST_WBACK || state_q == ST_FLUSH) ? cnt_q : req_off;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_ram #(.XLEN(XLEN), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_ram (
            .clk         (clk),
            .rst_b       (rst_b),
            .rd_index_i  (rd_index),
            .rd_offset_i (rd_offset),
            .rd_data_o   (rd_data[w]),
            .rd_meta_o   (rd_meta[w]),
            .data_we_i   (data_we[w]),
            .wr_index_i  (rd_index),
            .wr_offset_i (wr_offset),
            .wr_data_i   (wr_data),
            .wr_strb_i   (wr_strb),
            .meta_we_i   (meta_we[w]),
            .wr_meta_i   (wr_meta)
        );
    end

    logic             hit;
    logic [WAY_W-1:0] hit_way, victim, cur_way, rr_next;
    cache_meta_t      cur_meta;
    logic [XLEN-1:0]  cur_data, refill_word;
    logic             rr_adv, flush_adv;

    // Descending scan so the lowest-index invalid way wins the victim slot.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = rr_q[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (rd_meta[w].valid && rd_meta[w].tag == req_tag_ext) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS-1; w >= 0; w--) begin
            if (!rd_meta[w].valid) victim = WAY_W'(w);
        end
    end

    assign cur_way  = (state_q == ST_FLUSH) ? flush_way_q : sel_way_q;
    assign cur_meta = rd_meta[cur_way];
    assign cur_data = rd_data[cur_way];
    assign rr_next  = (WAYS == 1 || rr_q[req_idx] == WAY_W'(WAYS-1)) ? '0 : rr_q[req_idx] + 1'b1;

    // A store that missed lands its bytes on the refilled word as it arrives.
    always_comb begin
        refill_word = bus.mem_rdata;
        if (req_we_q && cnt_q == req_off) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (wstrb_q[b]) refill_word[b*8 +: 8] = wdata_q[b*8 +: 8];
            end
        end
    end

    logic            req_ready, resp_valid, mem_valid, mem_we;
    logic [XLEN-1:0] resp_rdata, mem_addr;

    always_comb begin
        state_d      = state_q;
        req_we_d     = req_we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        cnt_d        = cnt_q;
        sel_way_d    = sel_way_q;
        flush_set_d  = flush_set_q;
        flush_way_d  = flush_way_q;
        flush_done_d = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        mem_valid    = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        data_we      = '0;
        meta_we      = '0;
        wr_offset    = cnt_q;
        wr_data      = refill_word;
        wr_strb      = '1;
        wr_meta      = '0;
        rr_adv       = 1'b0;
        flush_adv    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    flush_set_d = '0;
                    flush_way_d = '0;
                    cnt_d       = '0;
                    state_d     = ST_FLUSH;
                end else begin
                    req_ready = rst_b;
                    if (bus.req_valid) begin
                        req_we_d = bus.req_we;
                        addr_d   = bus.req_addr;
                        wdata_d  = bus.req_wdata;
                        wstrb_d  = bus.req_wstrb;
                        state_d  = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                cnt_d = '0;
                if (hit) begin
                    sel_way_d = hit_way;
                    if (req_we_q) begin
                        data_we[hit_way] = 1'b1;
                        meta_we[hit_way] = 1'b1;
                        wr_offset        = req_off;
                        wr_data          = wdata_q;
                        wr_strb          = wstrb_q;
                        wr_meta          = '{valid: 1'b1, dirty: 1'b1, tag: req_tag_ext};
                    end
                    state_d = ST_RESP;
                end else begin
                    sel_way_d = victim;
                    state_d   = (rd_meta[victim].valid && rd_meta[victim].dirty) ? ST_WBACK : ST_REFILL;
                end
            end
            ST_WBACK: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cur_meta.tag[TAG_W-1:0], req_idx, cnt_q, BYTE_W'(0)};
                if (bus.mem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(LINE_WORDS-1)) state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_valid = 1'b1;
                mem_addr  = {req_tag, req_idx, cnt_q, BYTE_W'(0)};
                if (bus.mem_ready) begin
                    data_we[sel_way_q] = 1'b1;
                    cnt_d              = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(LINE_WORDS-1)) begin
                        meta_we[sel_way_q] = 1'b1;
                        wr_meta            = '{valid: 1'b1, dirty: req_we_q, tag: req_tag_ext};
                        rr_adv             = 1'b1;
                        state_d            = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = cur_data;
                state_d    = ST_IDLE;
            end
            ST_FLUSH: begin
                if (cur_meta.valid && cur_meta.dirty) begin
                    mem_valid = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {cur_meta.tag[TAG_W-1:0], flush_set_q, cnt_q, BYTE_W'(0)};
                    if (bus.mem_ready) begin
                        cnt_d     = cnt_q + 1'b1;
                        flush_adv = (cnt_q == OFF_W'(LINE_WORDS-1));
                    end
                end else begin
                    flush_adv = 1'b1;
                end
                if (flush_adv) begin
                    meta_we[flush_way_q] = 1'b1;
                    if (flush_way_q == WAY_W'(WAYS-1)) begin
                        flush_way_d = '0;
                        flush_set_d = flush_set_q + 1'b1;
                        if (flush_set_q == IDX_W'(SETS-1)) begin
                            flush_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        flush_way_d = flush_way_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            req_we_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt_q        <= '0;
            sel_way_q    <= '0;
            flush_set_q  <= '0;
            flush_way_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_we_q     <= req_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            cnt_q        <= cnt_d;
            sel_way_q    <= sel_way_d;
            flush_set_q  <= flush_set_d;
            flush_way_q  <= flush_way_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (rr_adv) begin
            rr_q[req_idx] <= rr_next;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.mem_valid  = mem_valid;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = cur_data;
    assign bus.flush_done = flush_done_q;

endmodule
